sched_csr_gen: RTL and testbench
================================

Name: sched_csr_gen

Overview:
Scheduler-side producer of the scheduler-to-CSR status bundle: cycle counter, retired-instruction counter, per-warp active bits and per-warp thread masks. Tracks warp-control events (thread-mask change, warp spawn) and commit-stage retire pulses. Drives the master side of the scheduler/CSR interface consumed by the CSR unit. All outputs are registered.

Parameters:
NUM_WARPS, 4, number of hardware warps (power of two, >=2)
NUM_THREADS, 4, threads per warp
PERF_CTR_BITS, 44, width of the cycles and instret counters
COMMIT_WIDTH, 2, commit lanes that may retire one instruction each per cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
tmc_valid  in  1  thread-mask-change request this cycle
tmc_wid  in  log2(NUM_WARPS)  target warp of tmc
tmc_mask  in  NUM_THREADS  new thread mask; all-zero terminates the warp
wspawn_valid  in  1  warp-spawn request this cycle
wspawn_mask  in  NUM_WARPS  warps to activate
commit_valid  in  COMMIT_WIDTH  one bit per lane, each set bit = one retired instruction
cycles  out  PERF_CTR_BITS  cycle counter
instret  out  PERF_CTR_BITS  retired-instruction counter
active_warps  out  NUM_WARPS  warp active bits
thread_masks  out  NUM_WARPS x NUM_THREADS  per-warp thread mask
busy  out  1  OR of active_warps

Behaviour:
- Reset (sync, active-high, wins over all inputs in the same cycle): cycles=0, instret=0, active_warps=1 (warp 0 only), thread_masks[0]=1 (thread 0 only), thread_masks[w>0]=0, busy=1. Reset asserted mid-operation discards any pending event in that cycle.
- Latency: every input effect is visible on outputs exactly one cycle after the sampling edge. No combinational input-to-output path.
- cycles: +1 every non-reset cycle, unconditionally. Wraps modulo 2^PERF_CTR_BITS; no saturation.
- instret: += popcount(commit_valid) every non-reset cycle, 0..COMMIT_WIDTH. Popcount zero-extended to PERF_CTR_BITS. Wraps modulo 2^PERF_CTR_BITS.
- wspawn (applied first): for each w with wspawn_mask[w]=1: active_warps[w]=1, thread_masks[w]=1 (thread 0). Warps not in the mask are unchanged. Spawning an already-active warp resets its mask to thread 0.
- tmc (applied second, overrides wspawn on the same warp):
  - tmc_mask!=0: thread_masks[tmc_wid]=tmc_mask, active_warps[tmc_wid]=1.
  - tmc_mask==0: thread_masks[tmc_wid]=0, active_warps[tmc_wid]=0.
- Invariant: active_warps[w]==0 iff thread_masks[w]==0. Checked by assertion.
- Simultaneous tmc and wspawn on different warps: both take effect in the same cycle.
- When all warps terminate: busy=0 and cycles keeps counting. Only a wspawn or tmc can reactivate a warp.
- busy is derived from the registered active_warps (combinational OR of the register outputs).
- No handshake or backpressure: every event is accepted in the cycle it is presented.

Decomposition:
- VX_gpu_pkg: PERF_CTR_BITS, NW_BITS (=log2 NUM_WARPS).
- One sub-module: the existing VX_popcount, instantiated on commit_valid.
- Warp-state next-value logic stays inline: a two-pass priority merge (wspawn, then tmc) feeding one register bank.

Test Plan:
- Reset then idle 10 cycles -> cycles=10, instret=0, active_warps=4'b0001, thread_masks[0]=4'b0001, others 0, busy=1.
- commit_valid=2'b11 for 3 cycles, then 2'b01 for 1 cycle -> instret=7 one cycle after the last pulse.
- wspawn_mask=4'b1110 -> next cycle active_warps=4'b1111, thread_masks[1..3]=4'b0001. Then tmc wid=2, mask=4'b1011 -> thread_masks[2]=4'b1011.
- Same cycle: wspawn_mask=4'b0100 and tmc wid=2, mask=0 -> active_warps[2]=0, thread_masks[2]=0 (tmc wins). tmc wid=0 mask=0 with no other warps active -> busy=0 next cycle, cycles still increments.
- PERF_CTR_BITS=4: run 17 cycles after reset -> cycles=1 (wrap). instret at 4'hF plus 2 commits -> 4'h1.
- Reset asserted in the same cycle as wspawn and tmc -> outputs equal reset values next cycle, and the events are lost.

Source files
------------

// File: rtl/sched_csr_gen_pkg.sv
// Shared scheduler/CSR constants: default warp geometry and performance-counter width.
package sched_csr_gen_pkg;

   localparam int NUM_WARPS     = 4;
   localparam int NUM_THREADS   = 4;
   localparam int PERF_CTR_BITS = 44;
   localparam int COMMIT_WIDTH  = 2;
   localparam int NW_BITS       = $clog2(NUM_WARPS);

endpackage

// File: rtl/sched_csr_gen_chk.sv
// Invariant checker: a warp is active exactly when its thread mask is non-zero.
module sched_csr_gen_chk #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4
) (
   input logic                                    clk,
   input logic                                    reset,
   input logic [NUM_WARPS-1:0]                    active_warps,
   input logic [NUM_WARPS-1:0][NUM_THREADS-1:0]   thread_masks
);

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_inv
      a_active_iff_mask : assert property (@(posedge clk) disable iff (reset)
         (active_warps[w] == (|thread_masks[w])));
   end

endmodule

// File: rtl/sched_csr_gen_popcount.sv
// Population count of an N-bit vector; result wide enough to hold N.
module sched_csr_gen_popcount #(
   parameter int N = 2,
   parameter int W = $clog2(N + 1)
) (
   input  logic [N-1:0] in_bits,
   output logic [W-1:0] count
);

   // Sum of set bits
   always_comb begin
      count = W'(0);
      for (int i = 0; i < N; i++) begin
         count = count + W'(in_bits[i]);
      end
   end

endmodule

// File: rtl/sched_csr_gen.sv
// Scheduler-side producer of the CSR status bundle: perf counters, warp active bits and thread masks.
module sched_csr_gen
   import sched_csr_gen_pkg::*;
#(
   parameter int NUM_WARPS_P     = NUM_WARPS,
   parameter int NUM_THREADS_P   = NUM_THREADS,
   parameter int PERF_CTR_BITS_P = PERF_CTR_BITS,
   parameter int COMMIT_WIDTH_P  = COMMIT_WIDTH,
   parameter int NW_BITS_P       = $clog2(NUM_WARPS_P)
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        tmc_valid,
   input  logic [NW_BITS_P-1:0]                        tmc_wid,
   input  logic [NUM_THREADS_P-1:0]                    tmc_mask,
   input  logic                                        wspawn_valid,
   input  logic [NUM_WARPS_P-1:0]                      wspawn_mask,
   input  logic [COMMIT_WIDTH_P-1:0]                   commit_valid,
   output logic [PERF_CTR_BITS_P-1:0]                  cycles,
   output logic [PERF_CTR_BITS_P-1:0]                  instret,
   output logic [NUM_WARPS_P-1:0]                      active_warps,
   output logic [NUM_WARPS_P-1:0][NUM_THREADS_P-1:0]   thread_masks,
   output logic                                        busy
);

   localparam int CNT_W = $clog2(COMMIT_WIDTH_P + 1);

   logic [CNT_W-1:0]                                retire_cnt;
   logic [NUM_WARPS_P-1:0]                          next_active;
   logic [NUM_WARPS_P-1:0][NUM_THREADS_P-1:0]       next_masks;

   sched_csr_gen_popcount #(
      .N (COMMIT_WIDTH_P),
      .W (CNT_W)
   ) u_popcount (
      .in_bits (commit_valid),
      .count   (retire_cnt)
   );

   // Two-pass merge: wspawn first, then tmc so it overrides a spawn on the same warp
   always_comb begin
      next_active = active_warps;
      next_masks  = thread_masks;
      if (wspawn_valid) begin
         for (int w = 0; w < NUM_WARPS_P; w++) begin
            if (wspawn_mask[w]) begin
               next_active[w] = 1'b1;
               next_masks[w]  = NUM_THREADS_P'(1);
            end else begin
               next_active[w] = active_warps[w];
               next_masks[w]  = thread_masks[w];
            end
         end
      end else begin
         next_active = active_warps;
      end
      if (tmc_valid) begin
         next_masks[tmc_wid]  = tmc_mask;
         next_active[tmc_wid] = |tmc_mask;
      end else begin
         next_masks = next_masks;
      end
   end

   // Counter and warp-state register bank
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles       <= PERF_CTR_BITS_P'(0);
         instret      <= PERF_CTR_BITS_P'(0);
         active_warps <= NUM_WARPS_P'(1);
         for (int w = 0; w < NUM_WARPS_P; w++) begin
            thread_masks[w] <= (w == 0) ? NUM_THREADS_P'(1) : NUM_THREADS_P'(0);
         end
      end else begin
         cycles       <= cycles + PERF_CTR_BITS_P'(1);
         instret      <= instret + PERF_CTR_BITS_P'(retire_cnt);
         active_warps <= next_active;
         thread_masks <= next_masks;
      end
   end

   assign busy = |active_warps;

   sched_csr_gen_chk #(
      .NUM_WARPS   (NUM_WARPS_P),
      .NUM_THREADS (NUM_THREADS_P)
   ) u_chk (
      .clk          (clk),
      .reset        (reset),
      .active_warps (active_warps),
      .thread_masks (thread_masks)
   );

endmodule

// File: tb/tb_sched_csr_gen.sv
// Directed bench for sched_csr_gen: default 44-bit counters plus a 4-bit-counter instance for wrap checks.
module tb_sched_csr_gen;

   logic             clk = 1'b0;
   logic             reset;
   logic             tmc_valid;
   logic [1:0]       tmc_wid;
   logic [3:0]       tmc_mask;
   logic             wspawn_valid;
   logic [3:0]       wspawn_mask;
   logic [1:0]       commit_valid;

   logic [43:0]      cycles;
   logic [43:0]      instret;
   logic [3:0]       active_warps;
   logic [3:0][3:0]  thread_masks;
   logic             busy;

   logic [3:0]       cycles4;
   logic [3:0]       instret4;
   logic [3:0]       active_warps4;
   logic [3:0][3:0]  thread_masks4;
   logic             busy4;

   int ncmp = 0;
   int nerr = 0;
   longint ncyc = 0;

   always #5 clk = ~clk;

   sched_csr_gen u_dut (
      .clk (clk), .reset (reset),
      .tmc_valid (tmc_valid), .tmc_wid (tmc_wid), .tmc_mask (tmc_mask),
      .wspawn_valid (wspawn_valid), .wspawn_mask (wspawn_mask),
      .commit_valid (commit_valid),
      .cycles (cycles), .instret (instret),
      .active_warps (active_warps), .thread_masks (thread_masks), .busy (busy)
   );

   sched_csr_gen #(.PERF_CTR_BITS_P(4)) u_dut4 (
      .clk (clk), .reset (reset),
      .tmc_valid (tmc_valid), .tmc_wid (tmc_wid), .tmc_mask (tmc_mask),
      .wspawn_valid (wspawn_valid), .wspawn_mask (wspawn_mask),
      .commit_valid (commit_valid),
      .cycles (cycles4), .instret (instret4),
      .active_warps (active_warps4), .thread_masks (thread_masks4), .busy (busy4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ncyc = reset ? 0 : ncyc + 1;
   endtask

   task automatic idle();
      tmc_valid = 1'b0; tmc_wid = 2'd0; tmc_mask = 4'h0;
      wspawn_valid = 1'b0; wspawn_mask = 4'h0; commit_valid = 2'b00;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      chk("rst_cycles", cycles, 64'd0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_active", active_warps, 64'h1);
      chk("rst_masks", thread_masks, 64'h0001);
      chk("rst_busy", busy, 64'd1);

      reset = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("idle_cycles", cycles, 64'd10);
      chk("idle_cycles4", cycles4, 64'd10);
      chk("idle_instret", instret, 64'd0);
      chk("idle_masks", thread_masks, 64'h0001);
      chk("idle_busy", busy, 64'd1);

      commit_valid = 2'b11;
      for (int i = 0; i < 3; i++) tick();
      commit_valid = 2'b01;
      tick();
      chk("instret_7", instret, 64'd7);
      chk("instret4_7", instret4, 64'd7);

      commit_valid = 2'b11;
      for (int i = 0; i < 3; i++) tick();
      chk("cycles_17", cycles, 64'd17);
      chk("cycles4_wrap", cycles4, 64'd1);
      chk("instret_13", instret, 64'd13);
      tick();
      chk("instret4_f", instret4, 64'hF);
      tick();
      chk("instret4_wrap", instret4, 64'h1);
      chk("instret_17", instret, 64'd17);
      commit_valid = 2'b00;

      wspawn_valid = 1'b1; wspawn_mask = 4'b1110;
      tick();
      chk("spawn_active", active_warps, 64'hF);
      chk("spawn_masks", thread_masks, 64'h1111);

      idle();
      tmc_valid = 1'b1; tmc_wid = 2'd2; tmc_mask = 4'b1011;
      tick();
      chk("tmc_masks", thread_masks, 64'h1B11);
      chk("tmc_active", active_warps, 64'hF);

      wspawn_valid = 1'b1; wspawn_mask = 4'b0100;
      tmc_valid = 1'b1; tmc_wid = 2'd2; tmc_mask = 4'b0000;
      tick();
      chk("tmc_wins_active", active_warps, 64'hB);
      chk("tmc_wins_masks", thread_masks, 64'h1011);

      wspawn_valid = 1'b1; wspawn_mask = 4'b0100;
      tmc_valid = 1'b1; tmc_wid = 2'd1; tmc_mask = 4'b0110;
      tick();
      chk("both_active", active_warps, 64'hF);
      chk("both_masks", thread_masks, 64'h1161);

      idle();
      tmc_valid = 1'b1;
      tmc_wid = 2'd1; tick();
      tmc_wid = 2'd2; tick();
      tmc_wid = 2'd3; tick();
      chk("term3_active", active_warps, 64'h1);
      chk("term3_busy", busy, 64'd1);
      tmc_wid = 2'd0; tick();
      chk("term_all_active", active_warps, 64'h0);
      chk("term_all_masks", thread_masks, 64'h0);
      chk("term_all_busy", busy, 64'd0);
      chk("term_cycles", cycles, 64'(ncyc));
      idle();
      tick();
      chk("dead_busy", busy, 64'd0);
      chk("dead_cycles", cycles, 64'(ncyc));

      tmc_valid = 1'b1; tmc_wid = 2'd3; tmc_mask = 4'b1000;
      tick();
      chk("revive_active", active_warps, 64'h8);
      chk("revive_masks", thread_masks, 64'h8000);
      chk("revive_busy", busy, 64'd1);

      reset = 1'b1;
      wspawn_valid = 1'b1; wspawn_mask = 4'b1111;
      tmc_valid = 1'b1; tmc_wid = 2'd1; tmc_mask = 4'b1111;
      commit_valid = 2'b11;
      tick();
      chk("rst2_cycles", cycles, 64'd0);
      chk("rst2_instret", instret, 64'd0);
      chk("rst2_active", active_warps, 64'h1);
      chk("rst2_masks", thread_masks, 64'h0001);
      reset = 1'b0;
      idle();
      tick();
      chk("post_rst_active", active_warps, 64'h1);
      chk("post_rst_masks", thread_masks, 64'h0001);
      chk("post_rst_cycles", cycles, 64'd1);
      chk("post_rst_instret", instret, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
